aes_key_expansion: RTL and testbench
====================================

Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule. Produces the 1408-bit expanded key consumed by the round-key XOR stage of the cipher datapath.
- Takes a 128-bit cipher key on a start pulse and computes one round key per clock for rounds 1..NR.
- Presents all NR+1 round keys as one packed bus with a level "finish" flag.
- It is the writer side of the expanded-key interface; the round-key XOR stage reads `key[roundnumber*128 + i]`.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a synthesis-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cipher_key  input  128  cipher key. Bits [127:96] = w0; byte 0 of the key is bits [127:120].
- start  input  1  request expansion. Sampled on the clock edge; ignored while busy.
- key  output  128*(NR+1)  expanded key. Round r occupies [r*128 +: 128]; within a round, word w[4r] is at the top 32 bits.
- busy  output  1  expansion in progress.
- finish  output  1  level high while key holds a complete schedule.

Behaviour:
- Reset (rst=0, asynchronous):
  - key=0, busy=0, finish=0.
  - Round counter=0, rcon register=8'h01, state=IDLE.
  - Asserting reset mid-expansion aborts immediately; no partial result survives.
- States: IDLE, RUN.
- IDLE, start=1 at edge N:
  - key[127:0] <= cipher_key; the upper rounds are left stale.
  - Round counter <= 1, rcon <= 01, busy <= 1, finish <= 0, go to RUN.
- RUN, each edge with round counter r (1..NR):
  - prev = key[(r-1)*128 +: 128], split into words p0..p3, top word first.
  - t = SubWord(RotWord(p3)) XOR {rcon, 24'h0}.
  - n0 = p0^t, n1 = p1^n0, n2 = p2^n1, n3 = p3^n2.
  - key[r*128 +: 128] <= {n0,n1,n2,n3}.
  - rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1b : 0). This gives the sequence 01,02,04,08,10,20,40,80,1b,36.
  - If r==NR: busy <= 0, finish <= 1, go to IDLE. Otherwise r <= r+1.
- Latency: start sampled at edge N → finish high after edge N+NR (10 cycles). key is fully valid whenever finish=1.
- finish stays high until the next accepted start; it drops at that same edge.
- cipher_key is sampled only at the start edge. Later changes have no effect on the run in progress.
- start while busy: ignored; the run continues undisturbed. start held high in IDLE: a new run starts every NR+1 cycles.
- SubWord uses four combinational S-box instances, one per byte. Each S-box computes the GF(2^8) multiplicative inverse mod x^8+x^4+x^3+x+1 (0 maps to 0), then applies the FIPS-197 affine transform with constant 8'h63. There is no lookup table.
- Only key, busy, finish and the internal state are registered. The path from previous round to next round key is combinational within one cycle.
- Every bit of key is deterministic after reset (zero). No X is allowed on outputs at any time.

Test Plan:
- Reset, then start with cipher_key=2b7e151628aed2a6abf7158809cf4f3c:
  - finish rises exactly 10 cycles after the start edge.
  - Round 0 = cipher key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- cipher_key=0:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Confirms S-box(0)=63 and the rcon chain.
- Pulse start again at cycle 4 of a run with a different cipher_key:
  - The start is ignored.
  - Results equal the first key's schedule; busy never deasserts early.
- Drive rst low at cycle 5 of a run:
  - key=0, busy=0 and finish=0 asynchronously.
  - After release, a fresh start produces correct vectors.
- With finish=1, start a new run:
  - finish drops at the start edge.
  - Changing cipher_key after the start edge does not alter the result.
- Back-to-back: hold start high for 25 cycles. finish pulses high for exactly one cycle between runs, and both runs produce correct keys.

Source files
------------

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock, all NR+1 round keys
// presented on a packed bus, with a level finish flag once the schedule is complete.
//
// state | meaning
// IDLE  | waiting for start; key holds the last schedule (or zero after reset)
// RUN   | computing round key round_q from round key round_q-1

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // Inverse as a^254 via an addition chain; 0 naturally maps to 0.
  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, a);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, a);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, a);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, a);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, a);
    inv  = gf_mul(x127, x127);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expansion #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [127:0]            cipher_key,
  input  logic                    start,
  output logic [128*(NR+1)-1:0]   key,
  output logic                    busy,
  output logic                    finish
);
  generate
    if (NR != 10) begin : g_nr_check
      $error("aes_key_expansion supports only NR = 10");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              round_q;
  logic [7:0]              rcon_q;
  logic                    finish_q;
  logic [128*(NR+1)-1:0]   key_q;
  logic                    load, step, last;

  logic [127:0] prev_rk, next_rk;
  logic [31:0]  p0, p1, p2, p3, rot_w, sub_w, t_w, n0, n1, n2, n3;

  always_comb begin
    prev_rk = key_q[127:0];
    for (int r = 1; r <= NR; r++) begin
      if (round_q == 4'(r)) prev_rk = key_q[(r-1)*128 +: 128];
    end
  end

  assign {p0, p1, p2, p3} = prev_rk;
  assign rot_w = {p3[23:0], p3[31:24]};

  aes_sbox u_sbox3 (.a(rot_w[31:24]), .s(sub_w[31:24]));
  aes_sbox u_sbox2 (.a(rot_w[23:16]), .s(sub_w[23:16]));
  aes_sbox u_sbox1 (.a(rot_w[15:8]),  .s(sub_w[15:8]));
  aes_sbox u_sbox0 (.a(rot_w[7:0]),   .s(sub_w[7:0]));

  assign t_w = sub_w ^ {rcon_q, 24'h0};
  assign n0 = p0 ^ t_w;
  assign n1 = p1 ^ n0;
  assign n2 = p2 ^ n1;
  assign n3 = p3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (round_q == 4'(NR)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = (state_q == IDLE) && start;
    step = (state_q == RUN);
    last = step && (round_q == 4'(NR));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q    <= '0;
      round_q  <= 4'd0;
      rcon_q   <= 8'h01;
      finish_q <= 1'b0;
    end else if (load) begin
      key_q[127:0] <= cipher_key;
      round_q      <= 4'd1;
      rcon_q       <= 8'h01;
      finish_q     <= 1'b0;
    end else if (step) begin
      for (int r = 1; r <= NR; r++) begin
        if (round_q == 4'(r)) key_q[r*128 +: 128] <= next_rk;
      end
      rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      if (last) finish_q <= 1'b1;
      else      round_q  <= round_q + 4'd1;
    end
  end

  assign key    = key_q;
  assign busy   = (state_q == RUN);
  assign finish = finish_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for the AES-128 key schedule: FIPS-197 vectors from a table,
// plus sequences for ignored start, mid-run reset, restart and back-to-back runs.
module tb_aes_key_expansion;
  localparam int NR = 10;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [127:0]          cipher_key = '0;
  logic                  start = 1'b0;
  logic [128*(NR+1)-1:0] key;
  logic                  busy;
  logic                  finish;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ      = 128'h0;
  localparam logic [127:0] KZ_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ_R2   = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] KZ_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expansion #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .cipher_key(cipher_key), .start(start),
    .key(key), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ck;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return key[r*128 +: 128];
  endfunction

  // Start a run; at cycle inj (1..9) drive start=inj_start and cipher_key=inj_key for one edge.
  task automatic run_with(input logic [127:0] ck, input int inj, input logic inj_start,
                          input logic [127:0] inj_key, input string tag);
    logic early;
    cipher_key = ck;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_on"}, {127'h0, busy}, 128'h1);
    chk({tag, "_finish_off"}, {127'h0, finish}, 128'h0);
    early = 1'b0;
    for (int i = 1; i <= NR - 1; i++) begin
      if (i == inj) begin
        start = inj_start;
        cipher_key = inj_key;
      end
      tick();
      start = 1'b0;
      if (!(busy === 1'b1 && finish === 1'b0)) early = 1'b1;
    end
    chk({tag, "_no_early_end"}, {127'h0, early}, 128'h0);
    tick();
    chk({tag, "_finish_at_10"}, {127'h0, finish}, 128'h1);
    chk({tag, "_busy_off"}, {127'h0, busy}, 128'h0);
  endtask

  initial begin
    logic [127:0] last_ck;
    logic         have_run;
    logic         fin_bad;

    vecs[0] = '{K1, 0,  K1};
    vecs[1] = '{K1, 1,  K1_R1};
    vecs[2] = '{K1, 2,  K1_R2};
    vecs[3] = '{K1, 10, K1_R10};
    vecs[4] = '{KZ, 0,  KZ};
    vecs[5] = '{KZ, 1,  KZ_R1};
    vecs[6] = '{KZ, 2,  KZ_R2};
    vecs[7] = '{KZ, 10, KZ_R10};

    // Reset state
    #12;
    chk("reset_key_zero", {127'h0, (key === '0)}, 128'h1);
    chk("reset_busy", {127'h0, busy}, 128'h0);
    chk("reset_finish", {127'h0, finish}, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Table-driven schedules
    have_run = 1'b0;
    last_ck  = '0;
    for (int v = 0; v < 8; v++) begin
      if (!have_run || vecs[v].ck !== last_ck) begin
        run_with(vecs[v].ck, 0, 1'b0, '0, "tbl");
        last_ck  = vecs[v].ck;
        have_run = 1'b1;
      end
      chk($sformatf("tbl_v%0d_round%0d", v, vecs[v].rnd), rk(vecs[v].rnd), vecs[v].exp);
    end

    // Start pulse with a different key at cycle 4 is ignored
    tick();
    run_with(K1, 4, 1'b1, KZ, "ign");
    chk("ign_round1", rk(1), K1_R1);
    chk("ign_round10", rk(10), K1_R10);
    chk("ign_round0", rk(0), K1);

    // Asynchronous reset mid-run
    tick();
    cipher_key = KZ;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_key_zero", {127'h0, (key === '0)}, 128'h1);
    chk("midrst_busy", {127'h0, busy}, 128'h0);
    chk("midrst_finish", {127'h0, finish}, 128'h0);
    #2;
    rst = 1'b1;
    tick();
    run_with(KZ, 0, 1'b0, '0, "postrst");
    chk("postrst_round1", rk(1), KZ_R1);
    chk("postrst_round10", rk(10), KZ_R10);

    // Restart from finish=1; key changes right after the start edge
    tick();
    chk("restart_finish_held", {127'h0, finish}, 128'h1);
    run_with(K1, 1, 1'b0, KZ, "restart");
    chk("restart_round1", rk(1), K1_R1);
    chk("restart_round10", rk(10), K1_R10);

    // Back-to-back: start held for 25 edges; key switches to zero after the first edge
    tick();
    cipher_key = K1;
    start = 1'b1;
    fin_bad = 1'b0;
    tick();
    for (int i = 1; i <= 24; i++) begin
      if (i == 1) cipher_key = KZ;
      tick();
      if (finish !== ((i == 10) || (i == 21))) fin_bad = 1'b1;
      if (i == 10) begin
        chk("b2b_run1_round1", rk(1), K1_R1);
        chk("b2b_run1_round10", rk(10), K1_R10);
      end
      if (i == 21) begin
        chk("b2b_run2_round1", rk(1), KZ_R1);
        chk("b2b_run2_round10", rk(10), KZ_R10);
      end
    end
    start = 1'b0;
    chk("b2b_finish_pulses", {127'h0, fin_bad}, 128'h0);
    for (int i = 0; i < 12; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
